subtraction_game_ctrl: RTL and testbench

Game controller for the two-player subtraction game: holds the pile, enforces move rules, tracks whose turn it is, forfeits stalled turns and detects the winner. Sits directly upstream of the seven-segment display driver and produces its `win`, `plr_turn`, `pile_size`, `max_sub`, `max_add` and `hide` inputs. Button inputs arrive already debounced as single-cycle pulses in the `clk` domain.

---
 rtl/subtraction_game_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_subtraction_game_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subtraction_game_ctrl.sv
// subtraction_game_ctrl
//   Game controller for the two-player subtraction game. It holds the pile,
//   checks every move against the configured limits, tracks whose turn it
//   is, forfeits a turn that stalls for too long and detects the winner.
//   All outputs come straight from flops, so button effects appear one
//   cycle after the pulse is sampled.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   start        pulse: load configuration and begin a new game
//   pile_init    starting pile (clamped into 1..99)
//   max_sub_cfg  per-move subtract limit (0 is treated as 1)
//   max_add_cfg  per-move add limit (0 disables adds)
//   amt          move amount, sampled with a button pulse
//   btn_sub      pulse: subtract amt from the pile
//   btn_add      pulse: add amt to the pile
//   win          game over; plr_turn holds the winner
//   plr_turn     0 = player 1, 1 = player 2
//   pile_size    current pile, 0..99
//   max_sub      latched subtract limit
//   max_add      latched add limit
//   hide         high while no game is loaded
//   err          one-cycle pulse on a rejected move
//   tmo          one-cycle pulse on a turn forfeit

module subtraction_game_ctrl #(
  parameter int TURN_TIMEOUT = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] pile_init,
  input  logic [2:0] max_sub_cfg,
  input  logic [2:0] max_add_cfg,
  input  logic [2:0] amt,
  input  logic       btn_sub,
  input  logic       btn_add,
  output logic       win,
  output logic       plr_turn,
  output logic [6:0] pile_size,
  output logic [2:0] max_sub,
  output logic [2:0] max_add,
  output logic       hide,
  output logic       err,
  output logic       tmo
);

  localparam int CW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TURN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_WIN
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    pile_q, pile_d;
  logic          turn_q, turn_d;
  logic          win_q, win_d;
  logic          hide_q, hide_d;
  logic [2:0]    max_sub_q, max_sub_d;
  logic [2:0]    max_add_q, max_add_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic [1:0]    tok_q, tok_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0]    add_sum;
  logic [6:0]    sub_result;
  logic          sub_legal;
  logic          add_legal;
  logic          move_ok;
  logic [6:0]    pile_clamped;

  // The add check is done one bit wider than the pile so a sum above 127
  // cannot wrap around and slip under the 99 limit.
  assign add_sum    = {1'b0, pile_q} + {5'b0, amt};
  assign sub_result = pile_q - {4'b0, amt};

  assign sub_legal = (amt != 3'd0) && (amt <= max_sub_q) && ({4'b0, amt} <= pile_q);

  // Each player owns one add token per game; tok_q[0] belongs to player 1.
  assign add_legal = (max_add_q != 3'd0) && (amt != 3'd0) && (amt <= max_add_q) &&
                     tok_q[turn_q] && (add_sum <= 8'd99);

  assign pile_clamped = (pile_init == 7'd0)  ? 7'd1  :
                        (pile_init > 7'd99)  ? 7'd99 : pile_init;

  // Next-state logic. A legal move takes precedence over an expiring turn
  // timer; a rejected move leaves the timer running. start overrides
  // everything that happens in the same cycle.
  always_comb begin
    state_d   = state_q;
    pile_d    = pile_q;
    turn_d    = turn_q;
    win_d     = win_q;
    hide_d    = hide_q;
    max_sub_d = max_sub_q;
    max_add_d = max_add_q;
    tok_d     = tok_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    tmo_d     = 1'b0;
    move_ok   = 1'b0;

    case (state_q)
      ST_PLAY: begin
        if (btn_sub && btn_add) begin
          err_d = 1'b1;
        end else if (btn_sub) begin
          if (sub_legal) begin
            move_ok = 1'b1;
            pile_d  = sub_result;
            if (sub_result == 7'd0) begin
              // The player who empties the pile wins, so the turn stays put.
              state_d = ST_WIN;
              win_d   = 1'b1;
            end else begin
              turn_d = ~turn_q;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (btn_add) begin
          if (add_legal) begin
            move_ok        = 1'b1;
            pile_d         = add_sum[6:0];
            tok_d[turn_q]  = 1'b0;
            turn_d         = ~turn_q;
          end else begin
            err_d = 1'b1;
          end
        end

        if (move_ok) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          turn_d = ~turn_q;
          cnt_d  = '0;
          tmo_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE, ST_WIN: begin
        cnt_d = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (start) begin
      state_d   = ST_PLAY;
      pile_d    = pile_clamped;
      max_sub_d = (max_sub_cfg == 3'd0) ? 3'd1 : max_sub_cfg;
      max_add_d = max_add_cfg;
      turn_d    = 1'b0;
      win_d     = 1'b0;
      hide_d    = 1'b0;
      tok_d     = 2'b11;
      cnt_d     = '0;
      err_d     = 1'b0;
      tmo_d     = 1'b0;
    end
  end

  // State register with synchronous reset back to an unloaded game.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pile_q    <= 7'd0;
      turn_q    <= 1'b0;
      win_q     <= 1'b0;
      hide_q    <= 1'b1;
      max_sub_q <= 3'd0;
      max_add_q <= 3'd0;
      tok_q     <= 2'b11;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pile_q    <= pile_d;
      turn_q    <= turn_d;
      win_q     <= win_d;
      hide_q    <= hide_d;
      max_sub_q <= max_sub_d;
      max_add_q <= max_add_d;
      tok_q     <= tok_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign win       = win_q;
  assign plr_turn  = turn_q;
  assign pile_size = pile_q;
  assign max_sub   = max_sub_q;
  assign max_add   = max_add_q;
  assign hide      = hide_q;
  assign err       = err_q;
  assign tmo       = tmo_q;

endmodule

// File: tb/tb_subtraction_game_ctrl.sv
// tb_subtraction_game_ctrl
//   Drives directed game scenarios followed by random play into
//   subtraction_game_ctrl. A game-rule model predicts the outputs after
//   every edge; predictions go into a queue and a separate monitor compares
//   them with the DUT outputs one cycle later.

module tb_subtraction_game_ctrl;

  localparam int TT = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] pile_init;
  logic [2:0] max_sub_cfg;
  logic [2:0] max_add_cfg;
  logic [2:0] amt;
  logic       btn_sub;
  logic       btn_add;
  logic       win;
  logic       plr_turn;
  logic [6:0] pile_size;
  logic [2:0] max_sub;
  logic [2:0] max_add;
  logic       hide;
  logic       err;
  logic       tmo;

  subtraction_game_ctrl #(.TURN_TIMEOUT(TT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pile_init  (pile_init),
    .max_sub_cfg(max_sub_cfg),
    .max_add_cfg(max_add_cfg),
    .amt        (amt),
    .btn_sub    (btn_sub),
    .btn_add    (btn_add),
    .win        (win),
    .plr_turn   (plr_turn),
    .pile_size  (pile_size),
    .max_sub    (max_sub),
    .max_add    (max_add),
    .hide       (hide),
    .err        (err),
    .tmo        (tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int win;
    int turn;
    int pile;
    int msub;
    int madd;
    int hide;
    int err;
    int tmo;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   cycleNo     = 0;

  // Game-rule model: a game is either not loaded, being played, or over.
  bit m_loaded;
  bit m_over;
  int m_pile;
  int m_turn;
  int m_msub;
  int m_madd;
  int m_idle;
  bit m_tok[2];

  task automatic modelStep(input bit r, input bit s, input int pinit, input int cs,
                           input int ca, input int a, input bit bs, input bit ba,
                           output exp_t e);
    bit moved;
    e.err  = 0;
    e.tmo  = 0;
    moved  = 0;
    if (r) begin
      m_loaded = 0; m_over = 0; m_pile = 0; m_turn = 0;
      m_msub = 0; m_madd = 0; m_idle = 0; m_tok[0] = 1; m_tok[1] = 1;
    end else if (s) begin
      m_loaded = 1; m_over = 0;
      m_pile = (pinit == 0) ? 1 : ((pinit > 99) ? 99 : pinit);
      m_msub = (cs == 0) ? 1 : cs;
      m_madd = ca;
      m_turn = 0; m_idle = 0; m_tok[0] = 1; m_tok[1] = 1;
    end else if (m_loaded && !m_over) begin
      if (bs && ba) begin
        e.err = 1;
      end else if (bs) begin
        if (a >= 1 && a <= m_msub && a <= m_pile) begin
          m_pile -= a;
          moved = 1;
          if (m_pile == 0) m_over = 1;
          else m_turn = 1 - m_turn;
        end else begin
          e.err = 1;
        end
      end else if (ba) begin
        if (m_madd != 0 && a >= 1 && a <= m_madd && m_tok[m_turn] && m_pile + a <= 99) begin
          m_pile += a;
          m_tok[m_turn] = 0;
          m_turn = 1 - m_turn;
          moved = 1;
        end else begin
          e.err = 1;
        end
      end
      if (moved) begin
        m_idle = 0;
      end else if (m_idle == TT - 1) begin
        m_turn = 1 - m_turn;
        m_idle = 0;
        e.tmo  = 1;
      end else begin
        m_idle++;
      end
    end
    e.win  = m_over ? 1 : 0;
    e.hide = m_loaded ? 0 : 1;
    e.pile = m_pile;
    e.turn = m_turn;
    e.msub = m_msub;
    e.madd = m_madd;
  endtask

  // Drive one cycle of inputs on the falling edge and queue the prediction
  // for the state after the following rising edge.
  task automatic applyStimulus(input bit r, input bit s, input int pinit, input int cs,
                               input int ca, input int a, input bit bs, input bit ba);
    exp_t e;
    @(negedge clk);
    rst         = r;
    start       = s;
    pile_init   = 7'(pinit);
    max_sub_cfg = 3'(cs);
    max_add_cfg = 3'(ca);
    amt         = 3'(a);
    btn_sub     = bs;
    btn_add     = ba;
    modelStep(r, s, pinit, cs, ca, a, bs, ba, e);
    expQ.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic newGame(input int pinit, input int cs, input int ca);
    applyStimulus(0, 1, pinit, cs, ca, 0, 0, 0);
  endtask

  task automatic doSub(input int a);
    applyStimulus(0, 0, 0, 0, 0, a, 1, 0);
  endtask

  task automatic doAdd(input int a);
    applyStimulus(0, 0, 0, 0, 0, a, 0, 1);
  endtask

  task automatic checkOutput(input string name, input int act, input int req);
    assertCount++;
    if (act != req) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycleNo);
    end
  endtask

  // Monitor: one prediction per cycle, compared shortly after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycleNo++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("win",       int'(win),       e.win);
        checkOutput("plr_turn",  int'(plr_turn),  e.turn);
        checkOutput("pile_size", int'(pile_size), e.pile);
        checkOutput("max_sub",   int'(max_sub),   e.msub);
        checkOutput("max_add",   int'(max_add),   e.madd);
        checkOutput("hide",      int'(hide),      e.hide);
        checkOutput("err",       int'(err),       e.err);
        checkOutput("tmo",       int'(tmo),       e.tmo);
      end
    end
  end

  initial begin
    int r;
    int drain;
    rst = 1'b1; start = 1'b0; pile_init = '0; max_sub_cfg = '0; max_add_cfg = '0;
    amt = '0; btn_sub = 1'b0; btn_add = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
    idleCycles(2);

    $display("[TB] basic subtract");
    newGame(10, 3, 2);
    doSub(3);

    $display("[TB] win");
    newGame(4, 3, 0);
    doSub(1);
    doSub(3);
    doSub(2);
    doAdd(1);
    idleCycles(3);

    $display("[TB] illegal moves");
    newGame(10, 3, 2);
    doSub(4);
    doSub(0);
    newGame(2, 3, 0);
    doSub(5);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);

    $display("[TB] adds");
    newGame(97, 3, 3);
    doAdd(2);
    doAdd(1);
    doSub(1);
    doAdd(1);
    newGame(20, 3, 0);
    doAdd(1);

    $display("[TB] timeout");
    newGame(30, 3, 2);
    idleCycles(TT);
    idleCycles(TT);
    newGame(30, 3, 2);
    idleCycles(TT - 1);
    doSub(1);
    idleCycles(TT);

    $display("[TB] clamp, priority, reset");
    newGame(0, 0, 0);
    newGame(120, 5, 1);
    applyStimulus(0, 1, 15, 2, 1, 2, 1, 0);
    doSub(2);
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0);
    doSub(1);

    $display("[TB] random play");
    newGame(12, 3, 2);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1)
        applyStimulus(1, 0, 0, 0, 0, $urandom_range(0, 7), $urandom_range(0, 1), 0);
      else if (r < 5)
        applyStimulus(0, 1, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 14) : $urandom_range(0, 127),
                      $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
      else if (r < 35)
        doSub(($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 3));
      else if (r < 47)
        doAdd($urandom_range(0, 7));
      else if (r < 49)
        applyStimulus(0, 0, 0, 0, 0, $urandom_range(0, 7), 1, 1);
      else
        idleCycles(1);
    end
    idleCycles(1);

    drain = 0;
    while (expQ.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
